truth_table_sweeper: RTL and testbench

Sequencer that exhaustively drives an N-input combinational Boolean function (e.g. the SoP/PoS minterm blocks of the boolean-expression exercises) through all 2^N input combinations in ascending order. It samples the function output for each combination, assembles the observed truth table, and compares it against an expected minterm mask. It sits between a testbench or top-level control and one combinational function instance, replacing hand-written `#1` stimulus sequences.

---
 rtl/truth_table_sweeper.sv | 136 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks all 2^N_IN input combinations of a combinational
// function, samples its output per combination and compares against an expected minterm mask.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   f_in,
    output logic [N_IN-1:0]        x_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   match,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int unsigned W      = 1 << N_IN;
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(W - 1);
    localparam logic [3:0] RELOAD  = 4'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W-1:0]    table_q, table_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN-1:0] fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            match_q, match_d;

    // Table including the sample being taken this cycle, so the verdict sees the last bit.
    logic [W-1:0]    sample_tbl;
    logic [W-1:0]    diff;
    logic [N_IN-1:0] first_diff;
    logic [N_IN:0]   idx_next;

    always_comb begin
        sample_tbl = table_q;
        sample_tbl[idx_q[N_IN-1:0]] = f_in;
        diff = sample_tbl ^ exp_q;
        first_diff = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (diff[i]) first_diff = N_IN'(i);
        end
        idx_next = idx_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        table_d = table_q;
        x_d     = x_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        match_d = match_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    exp_d   = expected;
                    table_d = '0;
                    idx_d   = '0;
                    x_d     = '0;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                    match_d = 1'b0;
                    fail_d  = '0;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = StSample;
            end
            StSample: begin
                table_d = sample_tbl;
                if (idx_q == LAST) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (sample_tbl == exp_q);
                    fail_d  = first_diff;
                end else begin
                    idx_d   = idx_next;
                    x_d     = idx_next[N_IN-1:0];
                    cnt_d   = RELOAD;
                    state_d = StWait;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            x_q     <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            x_q     <= x_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign x_out     = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign match     = match_q;
    assign fail_idx  = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweeper instances (3-input f=y, settle 1; 2-input f=x&y, settle 3).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic [7:0] exp_a = 8'h00;
    logic       f_a, busy_a, done_a, match_a;
    logic [2:0] x_a, fi_a;
    logic [7:0] tbl_a;

    logic       start_b = 1'b0;
    logic [3:0] exp_b = 4'h0;
    logic       f_b, busy_b, done_b, match_b;
    logic [1:0] x_b, fi_b, prev_b;
    logic [3:0] tbl_b;
    logic       glitch_b = 1'b0;
    logic       glitch_en = 1'b0;

    assign f_a = x_a[1];
    assign f_b = (x_b[1] & x_b[0]) ^ glitch_b;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .f_in(f_a),
        .x_out(x_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
        .match(match_a), .fail_idx(fi_a)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .f_in(f_b),
        .x_out(x_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
        .match(match_b), .fail_idx(fi_b)
    );

    int total = 0;
    int bad = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        logic [3:0] fi;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // fsel 0: f = y (input bit 1); fsel 1: f = x & y (bits 1 and 0)
    function automatic exp_t model(input int n, input int fsel, input logic [7:0] e);
        exp_t r;
        logic [7:0] d;
        r.tbl = 8'h00;
        for (int i = 0; i < (1 << n); i++) begin
            r.tbl[i] = (fsel == 0) ? i[1] : (i[1] & i[0]);
        end
        r.m = (r.tbl == e);
        d = r.tbl ^ e;
        r.fi = 4'd0;
        for (int i = (1 << n) - 1; i >= 0; i--) begin
            if (d[i]) r.fi = i[3:0];
        end
        return r;
    endfunction

    // Corrupt f_b only in the first WAIT cycle after each x_out change.
    always @(posedge clk) begin
        prev_b = x_b;
        #1;
        glitch_b = glitch_en && (x_b != prev_b);
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            dcnt_a++;
            if (sb_a.size() == 0) begin
                check_eq("a_extra_done", 1, 0);
            end else begin
                e = sb_a.pop_front();
                check_eq("a_table", tbl_a, e.tbl);
                check_eq("a_match", match_a, e.m);
                check_eq("a_fail_idx", fi_a, e.fi);
            end
        end
        if (done_b) begin
            dcnt_b++;
            if (sb_b.size() == 0) begin
                check_eq("b_extra_done", 1, 0);
            end else begin
                e = sb_b.pop_front();
                check_eq("b_table", tbl_b, e.tbl);
                check_eq("b_match", match_b, e.m);
                check_eq("b_fail_idx", fi_b, e.fi);
            end
        end
    end

    // pulse[k] raises start during the cycle after E0+k (sampled at E0+k+1).
    task automatic run_a(input logic [7:0] e, input logic [17:0] pulse, input logic [7:0] echg);
        int n0;
        @(posedge clk); #1;
        start_a = 1'b1;
        exp_a = e;
        sb_a.push_back(model(3, 0, e));
        n0 = dcnt_a;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            start_a = pulse[k];
            if (k == 0) exp_a = echg;
            @(negedge clk);
            if (k < 16) begin
                check_eq("a_x_step", x_a, k / 2);
                check_eq("a_busy", busy_a, 1);
            end
            if (k == 15) check_eq("a_done_early", done_a, 0);
            if (k == 16) begin
                check_eq("a_done_pulse", done_a, 1);
                check_eq("a_busy_end", busy_a, 0);
                check_eq("a_x_hold", x_a, 7);
            end
            if (k == 17) check_eq("a_done_width", done_a, 0);
        end
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("a_done_count", dcnt_a, n0 + 1);
        check_eq("a_idle_after", busy_a, 0);
    endtask

    task automatic run_b(input logic [3:0] e);
        int n0;
        @(posedge clk); #1;
        start_b = 1'b1;
        exp_b = e;
        sb_b.push_back(model(2, 1, {4'h0, e}));
        n0 = dcnt_b;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            @(negedge clk);
            if (k < 16) check_eq("b_x_step", x_b, k / 4);
            if (k == 15) check_eq("b_done_early", done_b, 0);
            if (k == 16) check_eq("b_done_pulse", done_b, 1);
            if (k == 17) check_eq("b_done_width", done_b, 0);
        end
        #1;
        check_eq("b_done_count", dcnt_b, n0 + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        // Power-on reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        check_eq("rst_x", x_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_table", tbl_a, 0);
        check_eq("rst_match", match_a, 0);
        check_eq("rst_fail", fi_a, 0);
        check_eq("rst_b_busy", busy_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_a(8'hCC, 18'h0, 8'hCC);
        run_a(8'hCE, 18'h0, 8'hCE);
        run_a(8'h4C, 18'h0, 8'h4C);
        // start pulses sampled in WAIT, SAMPLE, WAIT and DONE
        run_a(8'hCC, 18'h10007, 8'hCC);
        // expected changed right after E0
        run_a(8'hCC, 18'h0, 8'h00);

        glitch_en = 1'b1;
        run_b(4'h8);
        run_b(4'h0);
        glitch_en = 1'b0;

        // start held high: second sweep follows through IDLE
        @(posedge clk); #1;
        start_a = 1'b1;
        exp_a = 8'hCC;
        sb_a.push_back(model(3, 0, 8'hCC));
        sb_a.push_back(model(3, 0, 8'hCC));
        n0 = dcnt_a;
        for (int i = 0; i < 40 && dcnt_a < n0 + 1; i++) begin
            @(negedge clk); #1;
        end
        check_eq("held_first_done", dcnt_a, n0 + 1);
        for (int i = 0; i < 4 && !busy_a; i++) begin
            @(negedge clk); #1;
        end
        check_eq("held_restart", busy_a, 1);
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 40 && dcnt_a < n0 + 2; i++) begin
            @(negedge clk); #1;
        end
        repeat (4) @(negedge clk);
        #1;
        check_eq("held_done_count", dcnt_a, n0 + 2);
        check_eq("held_idle", busy_a, 0);

        // Reset during combination 4
        @(posedge clk); #1;
        start_a = 1'b1;
        exp_a = 8'hCC;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 20 && x_a != 3'd4; i++) @(negedge clk);
        check_eq("mid_reach4", x_a, 4);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_x", x_a, 0);
        check_eq("mid_rst_busy", busy_a, 0);
        check_eq("mid_rst_table", tbl_a, 0);
        check_eq("mid_rst_match", match_a, 0);
        check_eq("mid_rst_done", done_a, 0);
        n0 = dcnt_a;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check_eq("mid_no_done", dcnt_a, n0);
        check_eq("mid_idle", busy_a, 0);
        run_a(8'hCC, 18'h0, 8'hCC);

        check_eq("sb_a_empty", sb_a.size(), 0);
        check_eq("sb_b_empty", sb_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
